probe_capture: RTL and testbench

Parametrised on-chip capture core for the data-acquisition path: samples a DATA_W-bit probe bus every clock (or every Nth clock), holds a ring buffer of 2^ADDR_W words, and freezes it around a programmable trigger with a programmable pre-trigger window. It sits in the PSRAM clock domain beside the acquisition datapath. The host bridge drives it through a level/strobe control port and a pipelined read port, so no vendor debug fabric is needed.

---
 rtl/probe_capture.sv | 247 ++++++++++++++++++++++++
 tb/tb_probe_capture.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/probe_capture.sv
// probe_capture: ring-buffer capture core with masked/edge trigger, pre-trigger window and pipelined readout.
// Build macro PROBE_CAPTURE_DECIM_EN adds the decim_i port and a sample-rate divider.
module probe_capture #(
  parameter int DATA_W = 22,
  parameter int ADDR_W = 10
) (
  input  logic              clk_PSRAM,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] probe_i,
  input  logic              arm_i,
  input  logic              abort_i,
  input  logic [DATA_W-1:0] trig_value_i,
  input  logic [DATA_W-1:0] trig_mask_i,
  input  logic [1:0]        trig_mode_i,
  input  logic [ADDR_W-1:0] pre_cnt_i,
`ifdef PROBE_CAPTURE_DECIM_EN
  input  logic [7:0]        decim_i,
`endif
  input  logic              rd_req_i,
  output logic              rd_valid_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_last_o,
  output logic [2:0]        state_o,
  output logic              triggered_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] trig_addr_o
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [1:0] MODE_MATCH    = 2'b00;
  localparam logic [1:0] MODE_RISE     = 2'b01;
  localparam logic [1:0] MODE_MISMATCH = 2'b10;
  localparam logic [1:0] MODE_IMM      = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRETRIG   = 3'd1,
    ST_WAIT_TRIG = 3'd2,
    ST_POSTTRIG  = 3'd3,
    ST_DONE      = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wp_q, wp_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                prev_match_q, prev_match_d;
  logic                triggered_q, triggered_d;
  logic [ADDR_W-1:0]   trig_addr_q, trig_addr_d;
  logic [ADDR_W-1:0]   rp_q, rp_d;
  logic [ADDR_W-1:0]   rd_cnt_q, rd_cnt_d;
  logic                rd_end_q, rd_end_d;

  logic [DATA_W-1:0]   trig_value_q;
  logic [DATA_W-1:0]   trig_mask_q;
  logic [1:0]          trig_mode_q;
  logic [ADDR_W-1:0]   pre_cnt_q;

  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   ram_rdata_q;
  logic                rd_v1_q, rd_l1_q;
  logic                rd_valid_q, rd_last_q;
  logic [DATA_W-1:0]   rd_data_q;

  logic                capturing;
  logic                strobe;
  logic                take;
  logic                match;
  logic                trig_hit;
  logic                we;
  logic                rd_accept;
  logic                flush;
  logic [ADDR_W-1:0]   post_cnt;

  assign capturing = (state_q == ST_PRETRIG) || (state_q == ST_WAIT_TRIG) ||
                     (state_q == ST_POSTTRIG);
  assign take      = capturing && strobe;
  assign match     = (((probe_i ^ trig_value_q) & trig_mask_q) == '0);
  assign flush     = arm_i || abort_i;
  // DEPTH-1-pre_cnt: samples still owed after the trigger sample
  assign post_cnt  = {ADDR_W{1'b1}} - pre_cnt_q;

  always_comb begin
    trig_hit = 1'b0;
    case (trig_mode_q)
      MODE_MATCH:    trig_hit = match;
      MODE_RISE:     trig_hit = match && !prev_match_q;
      MODE_MISMATCH: trig_hit = !match;
      MODE_IMM:      trig_hit = 1'b1;
      default:       trig_hit = 1'b0;
    endcase
  end

`ifdef PROBE_CAPTURE_DECIM_EN
  logic [7:0] decim_q;
  logic [7:0] dcnt_q;

  assign strobe = (dcnt_q == 8'd0);

  always_ff @(posedge clk_PSRAM) begin
    if (!rst_n) begin
      decim_q <= 8'd0;
      dcnt_q  <= 8'd0;
    end else if (arm_i) begin
      decim_q <= decim_i;
      dcnt_q  <= 8'd0;
    end else if (capturing) begin
      dcnt_q  <= (dcnt_q == decim_q) ? 8'd0 : dcnt_q + 8'd1;
    end
  end
`else
  assign strobe = 1'b1;
`endif

  always_comb begin
    state_d      = state_q;
    wp_d         = wp_q;
    cnt_d        = cnt_q;
    prev_match_d = prev_match_q;
    triggered_d  = triggered_q;
    trig_addr_d  = trig_addr_q;
    rp_d         = rp_q;
    rd_cnt_d     = rd_cnt_q;
    rd_end_d     = rd_end_q;
    we           = 1'b0;
    rd_accept    = 1'b0;

    if (take) begin
      we   = 1'b1;
      wp_d = wp_q + 1'b1;
    end

    case (state_q)
      ST_PRETRIG: begin
        if (take) begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == ADDR_W'(1)) state_d = ST_WAIT_TRIG;
        end
      end
      ST_WAIT_TRIG: begin
        if (take) begin
          prev_match_d = match;
          if (trig_hit) begin
            triggered_d = 1'b1;
            trig_addr_d = wp_q;
            rp_d        = wp_q - pre_cnt_q;
            cnt_d       = post_cnt;
            state_d     = (post_cnt == '0) ? ST_DONE : ST_POSTTRIG;
          end
        end
      end
      ST_POSTTRIG: begin
        if (take) begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == ADDR_W'(1)) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (rd_req_i && !rd_end_q) begin
          rd_accept = 1'b1;
          rp_d      = rp_q + 1'b1;
          if (&rd_cnt_q) rd_end_d = 1'b1;
          else           rd_cnt_d = rd_cnt_q + 1'b1;
        end
      end
      default: ;
    endcase

    // arm outranks abort, and both outrank anything the state did this cycle
    if (arm_i) begin
      state_d      = (pre_cnt_i == '0) ? ST_WAIT_TRIG : ST_PRETRIG;
      wp_d         = '0;
      cnt_d        = pre_cnt_i;
      prev_match_d = 1'b1;
      triggered_d  = 1'b0;
      trig_addr_d  = '0;
      rd_cnt_d     = '0;
      rd_end_d     = 1'b0;
      we           = 1'b0;
      rd_accept    = 1'b0;
    end else if (abort_i) begin
      state_d      = ST_IDLE;
      triggered_d  = 1'b0;
      we           = 1'b0;
      rd_accept    = 1'b0;
    end
  end

  always_ff @(posedge clk_PSRAM) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      wp_q         <= '0;
      cnt_q        <= '0;
      prev_match_q <= 1'b1;
      triggered_q  <= 1'b0;
      trig_addr_q  <= '0;
      rp_q         <= '0;
      rd_cnt_q     <= '0;
      rd_end_q     <= 1'b0;
      trig_value_q <= '0;
      trig_mask_q  <= '0;
      trig_mode_q  <= 2'b00;
      pre_cnt_q    <= '0;
      rd_v1_q      <= 1'b0;
      rd_l1_q      <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_last_q    <= 1'b0;
      rd_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      wp_q         <= wp_d;
      cnt_q        <= cnt_d;
      prev_match_q <= prev_match_d;
      triggered_q  <= triggered_d;
      trig_addr_q  <= trig_addr_d;
      rp_q         <= rp_d;
      rd_cnt_q     <= rd_cnt_d;
      rd_end_q     <= rd_end_d;
      if (arm_i) begin
        trig_value_q <= trig_value_i;
        trig_mask_q  <= trig_mask_i;
        trig_mode_q  <= trig_mode_i;
        pre_cnt_q    <= pre_cnt_i;
      end
      rd_v1_q    <= rd_accept && !flush;
      rd_l1_q    <= rd_accept && !flush && (&rd_cnt_q);
      rd_valid_q <= rd_v1_q && !flush;
      rd_last_q  <= rd_l1_q && !flush;
      if (rd_v1_q && !flush) rd_data_q <= ram_rdata_q;
    end
  end

  // Simple dual-port RAM: writes only while capturing, reads only in DONE
  always_ff @(posedge clk_PSRAM) begin
    if (we) mem_q[wp_q] <= probe_i;
    if (rd_accept) ram_rdata_q <= mem_q[rp_q];
  end

  assign rd_valid_o  = rd_valid_q;
  assign rd_data_o   = rd_data_q;
  assign rd_last_o   = rd_last_q;
  assign state_o     = state_q;
  assign triggered_o = triggered_q;
  assign done_o      = (state_q == ST_DONE);
  assign trig_addr_o = trig_addr_q;

endmodule

// File: tb/tb_probe_capture.sv
// Directed bench for probe_capture at DATA_W=8, ADDR_W=4 with an incrementing probe bus.
module tb_probe_capture;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] probe = 8'h00;
  logic       arm = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] tval = 8'h00;
  logic [7:0] tmask = 8'h00;
  logic [1:0] tmode = 2'b00;
  logic [3:0] pre = 4'd0;
`ifdef PROBE_CAPTURE_DECIM_EN
  logic [7:0] decim = 8'd0;
`endif
  logic       rd_req = 1'b0;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       rd_last;
  logic [2:0] state;
  logic       triggered;
  logic       done;
  logic [3:0] trig_addr;

  logic       auto_inc = 1'b0;
  int         total = 0;
  int         bad = 0;

  probe_capture #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk_PSRAM    (clk),
    .rst_n        (rst_n),
    .probe_i      (probe),
    .arm_i        (arm),
    .abort_i      (abort),
    .trig_value_i (tval),
    .trig_mask_i  (tmask),
    .trig_mode_i  (tmode),
    .pre_cnt_i    (pre),
`ifdef PROBE_CAPTURE_DECIM_EN
    .decim_i      (decim),
`endif
    .rd_req_i     (rd_req),
    .rd_valid_o   (rd_valid),
    .rd_data_o    (rd_data),
    .rd_last_o    (rd_last),
    .state_o      (state),
    .triggered_o  (triggered),
    .done_o       (done),
    .trig_addr_o  (trig_addr)
  );

  always #5 clk = ~clk;

  // Start of a new cycle: strobes drop, probe advances when auto_inc is set
  task automatic cyc();
    @(posedge clk);
    #1;
    if (auto_inc) probe = probe + 8'd1;
    arm = 1'b0;
    abort = 1'b0;
    rd_req = 1'b0;
  endtask

  task automatic read_all(input logic [7:0] start, input int step, input string name);
    logic       ev, el;
    logic [7:0] ed;
    for (int i = 0; i < 23; i++) begin
      cyc();
      rd_req = (i < 20);
      @(negedge clk);
      ev = (i >= 2) && (i < 18);
      el = (i == 17);
      ed = start + 8'((i - 2) * step);
      total++;
      if (rd_valid !== ev) begin
        bad++;
        $display("FAIL %s rd_valid[%0d] got=%0b exp=%0b", name, i, rd_valid, ev);
      end
      total++;
      if (rd_last !== el) begin
        bad++;
        $display("FAIL %s rd_last[%0d] got=%0b exp=%0b", name, i, rd_last, el);
      end
      if (ev) begin
        total++;
        if (rd_data !== ed) begin
          bad++;
          $display("FAIL %s rd_data[%0d] got=%02h exp=%02h", name, i - 2, rd_data, ed);
        end
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) cyc();
    @(negedge clk);
    total++;
    if ({state, rd_valid, rd_data, rd_last, triggered, done, trig_addr} !== 19'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%05h exp=00000",
               {state, rd_valid, rd_data, rd_last, triggered, done, trig_addr});
    end
    rst_n = 1'b1;
    cyc();
    @(negedge clk);
    total++;
    if (state !== 3'd0) begin
      bad++;
      $display("FAIL reset_idle state got=%0d exp=0", state);
    end
  endtask

  task automatic test_immediate();
    cyc();
    auto_inc = 1'b1;
    tmode = 2'b11; tval = 8'h00; tmask = 8'h00; pre = 4'd0;
    arm = 1'b1; probe = 8'hFF;
    cyc();
    @(negedge clk);
    total++;
    if (state !== 3'd2) begin bad++; $display("FAIL imm_state1 got=%0d exp=2", state); end
    cyc();
    @(negedge clk);
    total++;
    if (triggered !== 1'b1 || trig_addr !== 4'd0 || state !== 3'd3) begin
      bad++;
      $display("FAIL imm_trig trig=%0b addr=%0d state=%0d exp 1/0/3", triggered, trig_addr, state);
    end
    repeat (14) cyc();
    @(negedge clk);
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL imm_done_early got=%0b exp=0", done); end
    cyc();
    @(negedge clk);
    total++;
    if (done !== 1'b1 || state !== 3'd4) begin
      bad++;
      $display("FAIL imm_done got=%0b state=%0d exp 1/4", done, state);
    end
    read_all(8'h00, 1, "imm");
  endtask

  task automatic test_match();
    int n;
    cyc();
    auto_inc = 1'b1;
    tmode = 2'b00; tval = 8'h40; tmask = 8'hF0; pre = 4'd4;
    arm = 1'b1; probe = 8'hFF;
    cyc();
    @(negedge clk);
    total++;
    if (state !== 3'd1) begin bad++; $display("FAIL match_pretrig got=%0d exp=1", state); end
    n = 0;
    while (done !== 1'b1 && n < 200) begin cyc(); @(negedge clk); n++; end
    total++;
    if (n != 76) begin bad++; $display("FAIL match_done_cycles got=%0d exp=76", n); end
    total++;
    if (triggered !== 1'b1 || trig_addr !== 4'd0) begin
      bad++;
      $display("FAIL match_trig trig=%0b addr=%0d exp 1/0", triggered, trig_addr);
    end
    read_all(8'h3C, 1, "match");
  endtask

  task automatic test_rising();
    int n;
    cyc();
    auto_inc = 1'b0;
    tmode = 2'b01; tval = 8'h05; tmask = 8'hFF; pre = 4'd0;
    arm = 1'b1; probe = 8'h05;
    cyc();
    @(negedge clk);
    total++;
    if (state !== 3'd2) begin bad++; $display("FAIL rise_state got=%0d exp=2", state); end
    cyc();
    cyc();
    cyc();
    probe = 8'h00;
    @(negedge clk);
    total++;
    if (triggered !== 1'b0) begin bad++; $display("FAIL rise_held got=%0b exp=0", triggered); end
    cyc();
    probe = 8'h05;
    auto_inc = 1'b1;
    @(negedge clk);
    total++;
    if (triggered !== 1'b0) begin bad++; $display("FAIL rise_low got=%0b exp=0", triggered); end
    cyc();
    @(negedge clk);
    total++;
    if (triggered !== 1'b1 || trig_addr !== 4'd4) begin
      bad++;
      $display("FAIL rise_trig trig=%0b addr=%0d exp 1/4", triggered, trig_addr);
    end
    n = 0;
    while (done !== 1'b1 && n < 100) begin cyc(); @(negedge clk); n++; end
    total++;
    if (n != 15) begin bad++; $display("FAIL rise_done_cycles got=%0d exp=15", n); end
    read_all(8'h05, 1, "rise");
  endtask

  task automatic test_pre_full();
    int n;
    cyc();
    auto_inc = 1'b1;
    tmode = 2'b00; tval = 8'h2A; tmask = 8'hFF; pre = 4'd15;
    arm = 1'b1; probe = 8'hFF;
    cyc();
    @(negedge clk);
    total++;
    if (state !== 3'd1) begin bad++; $display("FAIL pre15_state got=%0d exp=1", state); end
    n = 0;
    while (triggered !== 1'b1 && n < 200) begin cyc(); @(negedge clk); n++; end
    total++;
    if (n != 43) begin bad++; $display("FAIL pre15_trig_cycles got=%0d exp=43", n); end
    total++;
    if (done !== 1'b1 || state !== 3'd4 || trig_addr !== 4'd10) begin
      bad++;
      $display("FAIL pre15_done done=%0b state=%0d addr=%0d exp 1/4/10", done, state, trig_addr);
    end
    read_all(8'h1B, 1, "pre15");
  endtask

  task automatic test_abort_reset();
    int n;
    cyc();
    auto_inc = 1'b0;
    tmode = 2'b00; tval = 8'hFF; tmask = 8'hFF; pre = 4'd0;
    arm = 1'b1; probe = 8'h00;
    cyc();
    @(negedge clk);
    total++;
    if (state !== 3'd2 || done !== 1'b0 || triggered !== 1'b0) begin
      bad++;
      $display("FAIL rearm state=%0d done=%0b trig=%0b exp 2/0/0", state, done, triggered);
    end
    cyc();
    abort = 1'b1;
    cyc();
    @(negedge clk);
    total++;
    if (state !== 3'd0 || done !== 1'b0 || triggered !== 1'b0) begin
      bad++;
      $display("FAIL abort state=%0d done=%0b trig=%0b exp 0/0/0", state, done, triggered);
    end
    for (int i = 0; i < 5; i++) begin
      cyc();
      rd_req = 1'b1;
      @(negedge clk);
      total++;
      if (rd_valid !== 1'b0) begin bad++; $display("FAIL idle_read[%0d] got=%0b exp=0", i, rd_valid); end
    end

    // abort while a read is in flight
    cyc();
    auto_inc = 1'b1;
    tmode = 2'b11; pre = 4'd0; arm = 1'b1;
    n = 0;
    while (done !== 1'b1 && n < 60) begin cyc(); @(negedge clk); n++; end
    total++;
    if (done !== 1'b1) begin bad++; $display("FAIL abort_rd_setup done got=%0b exp=1", done); end
    cyc();
    rd_req = 1'b1;
    cyc();
    rd_req = 1'b1;
    abort = 1'b1;
    cyc();
    @(negedge clk);
    total++;
    if (rd_valid !== 1'b0 || state !== 3'd0) begin
      bad++;
      $display("FAIL abort_mid_read valid=%0b state=%0d exp 0/0", rd_valid, state);
    end

    // reset during POSTTRIG
    cyc();
    tmode = 2'b11; pre = 4'd0; arm = 1'b1;
    cyc();
    cyc();
    cyc();
    @(negedge clk);
    total++;
    if (state !== 3'd3) begin bad++; $display("FAIL post_state got=%0d exp=3", state); end
    rst_n = 1'b0;
    cyc();
    @(negedge clk);
    total++;
    if ({state, rd_valid, rd_data, rd_last, triggered, done, trig_addr} !== 19'd0) begin
      bad++;
      $display("FAIL post_reset got=%05h exp=00000",
               {state, rd_valid, rd_data, rd_last, triggered, done, trig_addr});
    end
    rst_n = 1'b1;
  endtask

`ifdef PROBE_CAPTURE_DECIM_EN
  task automatic test_decim();
    int n;
    cyc();
    auto_inc = 1'b1;
    tmode = 2'b11; pre = 4'd0; decim = 8'd2;
    arm = 1'b1; probe = 8'hFF;
    n = 0;
    cyc();
    @(negedge clk);
    while (done !== 1'b1 && n < 200) begin cyc(); @(negedge clk); n++; end
    total++;
    if (n != 46) begin bad++; $display("FAIL decim_done_cycles got=%0d exp=46", n); end
    read_all(8'h00, 3, "decim");
  endtask
`endif

  initial begin
    test_reset();
    test_immediate();
    test_match();
    test_rising();
    test_pre_full();
    test_abort_reset();
`ifdef PROBE_CAPTURE_DECIM_EN
    test_decim();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
